// File: rtl/div16_seq.sv
// rtl/div16_seq.sv - iterative restoring unsigned divider, one quotient bit per clock
module div16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic             dbz;

  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic             co;
  logic             take;

  // The partial remainder stays below the divisor, so its top bit is always
  // zero between steps and only WIDTH bits are held.
  assign sh = {r, q[WIDTH-1]};
  assign {co, diff} = {1'b0, sh} + {1'b0, ~{1'b0, d}} + {{(WIDTH+1){1'b0}}, 1'b1};
  // diff[WIDTH] is zero whenever co is set; folding it in keeps the full difference observed.
  assign take = co & ~diff[WIDTH];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r   <= '0;
      q   <= '0;
      d   <= '0;
      cnt <= '0;
      dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              q   <= '1;
              r   <= dividend;
              dbz <= 1'b1;
            end else begin
              r   <= '0;
              q   <= dividend;
              d   <= divisor;
              cnt <= '0;
              dbz <= 1'b0;
            end
          end
        end
        RUN: begin
          r   <= take ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], take};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign quotient  = q;
  assign remainder = r;
  assign divByZero = dbz;

endmodule
